// File: rtl/l1_refill_biu.sv
// Byte-wide memory bus interface for the L1 cache: line refills, uncached
// single reads and write-through stores, with bus error and timeout faulting.
module l1_refill_biu #(
   parameter int ADDR_WIDTH = 24,
   parameter int LINE_WID   = 7,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  read_line_req,
   input  logic                  read_req,
   input  logic                  write_through_req,
   input  logic [ADDR_WIDTH-1:0] pa,
   input  logic [7:0]            wt_data,
   output logic [7:0]            line_data,
   output logic [LINE_WID:0]     addr_count,
   output logic                  line_write,
   output logic                  cache_entry_refill,
   output logic                  trans_rdy,
   output logic                  bus_error,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [7:0]            bus_wdata,
   output logic                  bus_rd,
   output logic                  bus_wr,
   input  logic [7:0]            bus_rdata,
   input  logic                  bus_ack,
   input  logic                  bus_err
);

   typedef enum logic [2:0] {IDLE, LINE, SRD, SWR, DONE} state_t;

   state_t                state, state_n;
   logic [LINE_WID-1:0]   index, index_n;
   logic [7:0]            tcount, tcount_n;
   logic [7:0]            line_data_n;
   logic [LINE_WID:0]     addr_count_n;
   logic                  line_write_n, cache_entry_refill_n, trans_rdy_n, bus_error_n;
   logic [ADDR_WIDTH-1:0] bus_addr_n;
   logic [7:0]            bus_wdata_n;
   logic                  bus_rd_n, bus_wr_n;
   logic                  fault;

   // An ack arriving in the same cycle the counter expires still wins.
   assign fault = bus_err || (!bus_ack && (tcount == 8'(TIMEOUT)));

   always_comb begin
      state_n              = state;
      index_n              = index;
      tcount_n             = tcount;
      line_data_n          = line_data;
      addr_count_n         = addr_count;
      bus_addr_n           = bus_addr;
      bus_wdata_n          = bus_wdata;
      bus_rd_n             = bus_rd;
      bus_wr_n             = bus_wr;
      line_write_n         = 1'b0;
      cache_entry_refill_n = 1'b0;
      trans_rdy_n          = 1'b0;
      bus_error_n          = 1'b0;
      unique case (state)
         IDLE: begin
            index_n  = '0;
            tcount_n = '0;
            if (read_line_req) begin
               state_n    = LINE;
               bus_addr_n = {pa[ADDR_WIDTH-1:LINE_WID], {LINE_WID{1'b0}}};
               bus_rd_n   = 1'b1;
            end else if (read_req) begin
               state_n    = SRD;
               bus_addr_n = pa;
               bus_rd_n   = 1'b1;
            end else if (write_through_req) begin
               state_n     = SWR;
               bus_addr_n  = pa;
               bus_wdata_n = wt_data;
               bus_wr_n    = 1'b1;
            end
         end
         LINE, SRD, SWR: begin
            if (fault) begin
               bus_error_n = 1'b1;
               bus_rd_n    = 1'b0;
               bus_wr_n    = 1'b0;
               state_n     = DONE;
            end else if (bus_ack) begin
               tcount_n = '0;
               if (state == LINE) begin
                  line_data_n  = bus_rdata;
                  addr_count_n = {1'b0, index};
                  line_write_n = 1'b1;
                  index_n      = index + LINE_WID'(1);
                  bus_addr_n   = {bus_addr[ADDR_WIDTH-1:LINE_WID], index_n};
                  if (&index) begin
                     cache_entry_refill_n = 1'b1;
                     trans_rdy_n          = 1'b1;
                     bus_rd_n             = 1'b0;
                     state_n              = DONE;
                  end
               end else begin
                  if (state == SRD) begin
                     line_data_n = bus_rdata;
                  end
                  trans_rdy_n = 1'b1;
                  bus_rd_n    = 1'b0;
                  bus_wr_n    = 1'b0;
                  state_n     = DONE;
               end
            end else begin
               tcount_n = tcount + 8'd1;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= IDLE;
         index              <= '0;
         tcount             <= '0;
         line_data          <= '0;
         addr_count         <= '0;
         line_write         <= 1'b0;
         cache_entry_refill <= 1'b0;
         trans_rdy          <= 1'b0;
         bus_error          <= 1'b0;
         bus_addr           <= '0;
         bus_wdata          <= '0;
         bus_rd             <= 1'b0;
         bus_wr             <= 1'b0;
      end else begin
         state              <= state_n;
         index              <= index_n;
         tcount             <= tcount_n;
         line_data          <= line_data_n;
         addr_count         <= addr_count_n;
         line_write         <= line_write_n;
         cache_entry_refill <= cache_entry_refill_n;
         trans_rdy          <= trans_rdy_n;
         bus_error          <= bus_error_n;
         bus_addr           <= bus_addr_n;
         bus_wdata          <= bus_wdata_n;
         bus_rd             <= bus_rd_n;
         bus_wr             <= bus_wr_n;
      end
   end

endmodule

// File: tb/tb_l1_refill_biu.sv
// Bench for l1_refill_biu: a byte-memory slave with wait/error/mute knobs and
// per-transaction checks against a lazily filled random memory model.
module tb_l1_refill_biu;

   localparam int K_LINE  = 0;
   localparam int K_READ  = 1;
   localparam int K_WRITE = 2;

   logic        clk;
   logic        rst;
   logic        read_line_req, read_req, write_through_req;
   logic [23:0] pa;
   logic [7:0]  wt_data;
   logic [7:0]  line_data;
   logic [7:0]  addr_count;
   logic        line_write, cache_entry_refill, trans_rdy, bus_error;
   logic [23:0] bus_addr;
   logic [7:0]  bus_wdata;
   logic        bus_rd, bus_wr;
   logic [7:0]  bus_rdata;
   logic        bus_ack, bus_err;

   int tests_run = 0;
   int tests_failed = 0;

   int waits = 0;
   int mute = 0;
   int err_index = -1;
   int wait_cnt = 0;

   int st_strobes, st_refills, st_trdy, st_err, st_pulse_k;
   int st_rd_cycles, st_wr_cycles, st_lw_end, st_refill_end;
   logic [7:0] st_last_data;

   logic [7:0] mem [int unsigned];

   l1_refill_biu dut (
      .clk(clk), .rst(rst),
      .read_line_req(read_line_req), .read_req(read_req),
      .write_through_req(write_through_req),
      .pa(pa), .wt_data(wt_data),
      .line_data(line_data), .addr_count(addr_count),
      .line_write(line_write), .cache_entry_refill(cache_entry_refill),
      .trans_rdy(trans_rdy), .bus_error(bus_error),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_rd(bus_rd), .bus_wr(bus_wr),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] get_mem(input logic [23:0] a);
      if (!mem.exists({8'd0, a})) mem[{8'd0, a}] = 8'($urandom);
      return mem[{8'd0, a}];
   endfunction

   // Slave: answers on the falling edge so the DUT samples a stable ack/err.
   always @(negedge clk) begin
      bus_ack = 1'b0;
      bus_err = 1'b0;
      if ((bus_rd || bus_wr) && mute == 0) begin
         if (wait_cnt >= waits) begin
            wait_cnt = 0;
            if (err_index >= 0 && bus_rd && int'(bus_addr[6:0]) == err_index) begin
               bus_err = 1'b1;
            end else begin
               bus_ack = 1'b1;
               if (bus_rd) bus_rdata = get_mem(bus_addr);
               else mem[{8'd0, bus_addr}] = bus_wdata;
            end
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      checkOutput({tag, "_ctl"}, {26'd0, bus_rd, bus_wr, line_write, cache_entry_refill,
                                  trans_rdy, bus_error}, 32'd0);
      checkOutput({tag, "_addr"}, {8'd0, bus_addr}, 32'd0);
      checkOutput({tag, "_data"}, {8'd0, line_data, addr_count, bus_wdata}, 32'd0);
   endtask

   // Runs one transaction, gathering statistics; reset is pulsed once rst_at bytes are strobed.
   task automatic applyStimulus(input int kind, input logic [23:0] addr, input logic [7:0] data,
                                input int rst_at);
      logic [23:0] base;
      logic [23:0] exp_addr;
      int idx;
      bit done;
      base = (kind == K_LINE) ? {addr[23:7], 7'd0} : addr;
      st_strobes = 0; st_refills = 0; st_trdy = 0; st_err = 0; st_pulse_k = 0;
      st_rd_cycles = 0; st_wr_cycles = 0; st_lw_end = 0; st_refill_end = 0;
      st_last_data = 8'h00;
      @(negedge clk);
      pa = addr;
      wt_data = data;
      read_line_req     = (kind == K_LINE);
      read_req          = (kind == K_READ);
      write_through_req = (kind == K_WRITE);
      @(negedge clk);
      read_line_req = 1'b0; read_req = 1'b0; write_through_req = 1'b0;
      pa = 24'($urandom);
      wt_data = 8'($urandom);
      idx = 0;
      done = 1'b0;
      for (int k = 1; k <= 1200 && !done; k++) begin
         if (k > 1) @(negedge clk);
         if (line_write) begin
            checkOutput("addr_count", {24'd0, addr_count}, idx);
            checkOutput("line_data", {24'd0, line_data}, {24'd0, get_mem(24'(base + idx))});
            idx++;
            st_strobes++;
         end
         if (bus_rd) st_rd_cycles++;
         if (bus_wr) begin
            st_wr_cycles++;
            checkOutput("bus_wdata", {24'd0, bus_wdata}, {24'd0, data});
         end
         if (bus_rd || bus_wr) begin
            exp_addr = (kind == K_LINE) ? 24'(base + idx) : addr;
            checkOutput("bus_addr", {8'd0, bus_addr}, {8'd0, exp_addr});
         end
         if (cache_entry_refill) st_refills++;
         if (trans_rdy || bus_error) begin
            checkOutput("rdy_err_exclusive", {31'd0, trans_rdy & bus_error}, 32'd0);
            if (trans_rdy) st_trdy++;
            if (bus_error) st_err++;
            st_pulse_k    = k;
            st_last_data  = line_data;
            st_lw_end     = line_write;
            st_refill_end = cache_entry_refill;
            done = 1'b1;
         end else if (rst_at >= 0 && idx == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            check_all_zero("reset_abort");
            rst = 1'b0;
            st_pulse_k = -1;
            done = 1'b1;
         end
      end
      checkOutput("finished_in_budget", {31'd0, done}, 32'd1);
      if (st_pulse_k > 0) begin
         @(negedge clk);
         checkOutput("done_quiet", {26'd0, bus_rd, bus_wr, line_write, cache_entry_refill,
                                    trans_rdy, bus_error}, 32'd0);
      end
   endtask

   initial begin
      int kind;
      int w;
      logic [23:0] a;
      logic [7:0]  d;
      rst = 1'b1;
      read_line_req = 1'b0; read_req = 1'b0; write_through_req = 1'b0;
      pa = 24'd0; wt_data = 8'd0;
      bus_rdata = 8'd0; bus_ack = 1'b0; bus_err = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset_state");
      rst = 1'b0;

      // Zero-wait refill of the line holding 0x012345.
      waits = 0;
      applyStimulus(K_LINE, 24'h012345, 8'h00, -1);
      checkOutput("zw_strobes", st_strobes, 128);
      checkOutput("zw_refills", st_refills, 1);
      checkOutput("zw_trdy", st_trdy, 1);
      checkOutput("zw_err", st_err, 0);
      checkOutput("zw_latency", st_pulse_k, 129);
      checkOutput("zw_rd_cycles", st_rd_cycles, 128);
      checkOutput("zw_final_strobes", {30'd0, st_lw_end[0], st_refill_end[0]}, 32'd3);

      // Three wait cycles per byte.
      waits = 3;
      applyStimulus(K_LINE, 24'($urandom), 8'h00, -1);
      checkOutput("ws_strobes", st_strobes, 128);
      checkOutput("ws_refills", st_refills, 1);
      checkOutput("ws_latency", st_pulse_k, 513);
      checkOutput("ws_rd_cycles", st_rd_cycles, 512);
      waits = 0;

      // Single read and single write.
      mem[32'h0000A5] = 8'h5A;
      applyStimulus(K_READ, 24'h0000A5, 8'h00, -1);
      checkOutput("srd_data", {24'd0, st_last_data}, 32'h5A);
      checkOutput("srd_trdy", st_trdy, 1);
      checkOutput("srd_latency", st_pulse_k, 2);
      checkOutput("srd_no_line_write", st_strobes + st_lw_end, 0);
      applyStimulus(K_WRITE, 24'h000010, 8'hC3, -1);
      checkOutput("swr_trdy", st_trdy, 1);
      checkOutput("swr_latency", st_pulse_k, 2);
      checkOutput("swr_wr_cycles", st_wr_cycles, 1);
      checkOutput("swr_mem", {24'd0, get_mem(24'h000010)}, 32'hC3);

      // Bus error on byte 40 of a refill.
      err_index = 40;
      applyStimulus(K_LINE, 24'h345678, 8'h00, -1);
      checkOutput("berr_strobes", st_strobes, 40);
      checkOutput("berr_err", st_err, 1);
      checkOutput("berr_trdy", st_trdy, 0);
      checkOutput("berr_refills", st_refills, 0);
      checkOutput("berr_latency", st_pulse_k, 42);
      err_index = -1;

      // Slave never answers a single read.
      mute = 1;
      applyStimulus(K_READ, 24'h00BEEF, 8'h00, -1);
      checkOutput("tmo_err", st_err, 1);
      checkOutput("tmo_trdy", st_trdy, 0);
      checkOutput("tmo_latency", st_pulse_k, 257);
      checkOutput("tmo_rd_cycles", st_rd_cycles, 256);
      mute = 0;

      // Reset at byte 60, then a fresh refill must start from index 0.
      applyStimulus(K_LINE, 24'h00F000, 8'h00, 60);
      checkOutput("rst_strobes", st_strobes, 60);
      checkOutput("rst_refills", st_refills, 0);
      applyStimulus(K_LINE, 24'h7F0080, 8'h00, -1);
      checkOutput("post_rst_strobes", st_strobes, 128);
      checkOutput("post_rst_refills", st_refills, 1);

      // Random mix of transactions and wait states.
      for (int t = 0; t < 6; t++) begin
         kind = int'($urandom_range(0, 2));
         w = int'($urandom_range(0, 2));
         a = 24'($urandom);
         d = 8'($urandom);
         waits = w;
         applyStimulus(kind, a, d, -1);
         checkOutput("rnd_trdy", st_trdy, 1);
         checkOutput("rnd_err", st_err, 0);
         checkOutput("rnd_strobes", st_strobes, (kind == K_LINE) ? 128 : 0);
         checkOutput("rnd_latency", st_pulse_k, (kind == K_LINE) ? 128 * (w + 1) + 1 : w + 2);
         if (kind == K_WRITE) begin
            applyStimulus(K_READ, a, 8'h00, -1);
            checkOutput("rnd_readback", {24'd0, st_last_data}, {24'd0, d});
         end else if (kind == K_READ) begin
            checkOutput("rnd_read_data", {24'd0, st_last_data}, {24'd0, get_mem(a)});
         end
      end
      waits = 0;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/l1_refill_biu.md
# l1_refill_biu

Bus interface unit directly downstream of the direct-mapped L1 instruction/data cache. It accepts the cache's line-refill, single-read and write-through requests and runs them as byte transfers on the SoC byte-wide memory bus. During a refill it streams bytes back as indexed write strobes, then returns one completion or error pulse.

## Interface
- ADDR_WIDTH, 24, physical byte address width
- LINE_WID, 7, log2 of line size in bytes (128-byte line = 1024-byte cache / 8 entries)
- TIMEOUT, 255, cycles without bus_ack/bus_err before a transfer is faulted (8-bit counter)

- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- read_line_req  in  1  cache requests a line refill of the line containing pa
- read_req  in  1  cache requests one uncached byte read at pa
- write_through_req  in  1  cache requests one byte write of wt_data to pa
- pa  in  ADDR_WIDTH  request physical byte address
- wt_data  in  8  write-through data
- line_data  out  8  last byte read from the bus (refill or single read)
- addr_count  out  LINE_WID+1  byte index within line of line_data
- line_write  out  1  one-cycle strobe: line_data/addr_count valid for cache write
- cache_entry_refill  out  1  one-cycle pulse: line complete, update tag
- trans_rdy  out  1  one-cycle pulse: transaction finished successfully
- bus_error  out  1  one-cycle pulse: transaction faulted (bus_err or timeout)
- bus_addr  out  ADDR_WIDTH  memory bus address
- bus_wdata  out  8  memory bus write data
- bus_rd  out  1  memory bus read request
- bus_wr  out  1  memory bus write request
- bus_rdata  in  8  memory bus read data, valid with bus_ack
- bus_ack  in  1  transfer completed
- bus_err  in  1  transfer failed (takes priority over bus_ack)

## Operation
- States: IDLE, LINE, SRD, SWR, DONE.
- IDLE: request priority read_line_req > read_req > write_through_req. Accepting a request latches pa (line fill: base = {pa[ADDR_WIDTH-1:LINE_WID], 0}) and wt_data, clears the index and timeout counters.
- LINE: bus_rd=1 and bus_addr = base + index. On each bus_ack, capture bus_rdata into line_data, set addr_count = index, pulse line_write, then increment the index. bus_rd stays high for back-to-back transfers. When the acked index is 2^LINE_WID-1, pulse line_write, cache_entry_refill and trans_rdy in the same cycle, drop bus_rd and go to DONE.
- SRD: bus_rd=1 and bus_addr=pa. On bus_ack, capture line_data, pulse trans_rdy and go to DONE. line_write stays 0.
- SWR: bus_wr=1, bus_addr=pa, bus_wdata=latched wt_data. On bus_ack, pulse trans_rdy and go to DONE.
- DONE: lasts one cycle. All requests are ignored, which covers the cycle in which the cache is still dropping its request. Then go to IDLE.
- Fault: bus_err sampled, or the timeout counter reaching TIMEOUT in LINE/SRD/SWR, causes the following in the next cycle: bus_error pulses, bus_rd/bus_wr drop, state goes to DONE. No trans_rdy, no cache_entry_refill. Bytes already strobed in a refill stay written, and the tag is not updated.
- Timeout counter resets on every bus_ack.
- addr_count bit LINE_WID is always 0 and is kept only for width compatibility.

## Timing
- Reset values: every output is 0 and the state is IDLE. Reset mid-transfer aborts immediately with no pulse, and bus_rd/bus_wr are 0 the following cycle.
- All outputs are registered. bus_ack/bus_err are sampled on the rising clk edge.
- Request seen in IDLE at edge N: bus_rd/bus_wr high from N+1.
- bus_ack sampled at edge M: line_write/trans_rdy/line_data/addr_count are valid during cycle M+1, and bus_addr advances in M+1.
- Zero-wait slave (ack while request high): refill takes 128 bus cycles, and trans_rdy is asserted 129 cycles after acceptance. Single read/write: trans_rdy 2 cycles after acceptance.
- line_data holds its value until the next captured byte. trans_rdy and bus_error are never asserted together.

## Test plan
- Zero-wait refill, pa=0x012345: bus_addr 0x012300..0x01237F. 128 line_write pulses with addr_count 0..127 and data matching the model. The final cycle has line_write, cache_entry_refill and trans_rdy all high. 130 cycles from request to IDLE.
- Refill with 3 wait cycles per byte: bus_addr held for 4 cycles per byte, addr_count order preserved, exactly one cache_entry_refill.
- Single read of 0x00A5 returning 0x5A: line_data=0x5A with trans_rdy and line_write=0. Single write of 0xC3 to 0x000010: bus_wr with bus_wdata=0xC3, one trans_rdy.
- bus_err on byte 40 of a refill: 40 line_write pulses, then bus_error, no cache_entry_refill, IDLE after DONE.
- Slave never acks a single read: bus_error exactly TIMEOUT+1 cycles after bus_rd rises.
- rst asserted at byte 60 of a refill: all outputs 0 next cycle. A new request after reset restarts from index 0.
